// File: rtl/mod_counter_updown.sv
// mod_counter_updown: WIDTH-bit programmable modulo up/down counter with start/stop/preload,
//   one-shot mode, terminal-count flag and tri-stated outputs gated by Enable_In.
// Ports: Clk_In, Reset_In (async, active-low); Enable_In (output enable, state keeps running);
//   Start/Stop/Load commands; Direction_In (0 up, 1 down); One_Shot_Mode_In;
//   Preload_Counter_Value_In; MOD_Value_In (0 means 2^WIDTH);
//   Counter_Running_Flag_Out, Counter_Rollover_Flag_Out (registered);
//   Terminal_Count_Flag_Out (combinational); Counter_Count_Out.
// Option: define MOD_COUNTER_PRESCALER_EN to add Prescale_Value_In (tick every value+1 cycles).
module mod_counter_updown #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      Clk_In,
  input  logic                      Reset_In,
  input  logic                      Enable_In,
  input  logic                      Start_Counter_Command_In,
  input  logic                      Stop_Counter_Command_In,
  input  logic                      Load_Counter_Value_Command_In,
  input  logic                      Direction_In,
  input  logic                      One_Shot_Mode_In,
  input  logic [WIDTH-1:0]          Preload_Counter_Value_In,
  input  logic [WIDTH-1:0]          MOD_Value_In,
`ifdef MOD_COUNTER_PRESCALER_EN
  input  logic [PRESCALE_WIDTH-1:0] Prescale_Value_In,
`endif
  output logic                      Counter_Running_Flag_Out,
  output logic                      Counter_Rollover_Flag_Out,
  output logic                      Terminal_Count_Flag_Out,
  output logic [WIDTH-1:0]          Counter_Count_Out
);

  localparam logic [WIDTH-1:0]          ONE  = WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PONE = PRESCALE_WIDTH'(1);

  logic [WIDTH-1:0]          count_q, count_d;
  logic                      running_q, running_d;
  logic                      rollover_q, rollover_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] presc_limit;
  logic [WIDTH-1:0]          term_val;
  logic [WIDTH-1:0]          load_val;
  logic                      tick;
  logic                      count_en;

  // Without the prescaler the limit is zero, so the prescaler register never
  // leaves zero and every running cycle is a tick.
`ifdef MOD_COUNTER_PRESCALER_EN
  assign presc_limit = Prescale_Value_In;
`else
  assign presc_limit = '0;
`endif

  // A zero modulus wraps to all ones, giving a full 2^WIDTH count range.
  assign term_val = MOD_Value_In - ONE;
  assign load_val = (Preload_Counter_Value_In > term_val) ? term_val : Preload_Counter_Value_In;

  assign tick = running_q && (presc_q == presc_limit);
  // A Stop freezes the count on the edge it is sampled, unless Start overrides it.
  assign count_en = tick && (Start_Counter_Command_In || !Stop_Counter_Command_In);

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    if (!running_q && Load_Counter_Value_Command_In) begin
      count_d = load_val;
    end else if (count_en) begin
      if (!Direction_In) begin
        // >= pulls a count left above a shrunken terminal value back to zero.
        if (count_q >= term_val) begin
          count_d    = '0;
          rollover_d = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if ((count_q == '0) || (count_q > term_val)) begin
          count_d    = term_val;
          rollover_d = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_comb begin
    running_d = running_q;
    if (Start_Counter_Command_In) begin
      running_d = 1'b1;
    end else if (Stop_Counter_Command_In) begin
      running_d = 1'b0;
    end else if (One_Shot_Mode_In && rollover_d) begin
      running_d = 1'b0;
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (Start_Counter_Command_In || Stop_Counter_Command_In || Load_Counter_Value_Command_In) begin
      presc_d = '0;
    end else if (running_q) begin
      presc_d = tick ? '0 : presc_q + PONE;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      count_q    <= '0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      count_q    <= count_d;
      running_q  <= running_d;
      rollover_q <= rollover_d;
      presc_q    <= presc_d;
    end
  end

  assign Counter_Running_Flag_Out  = Enable_In ? running_q  : 1'bz;
  assign Counter_Rollover_Flag_Out = Enable_In ? rollover_q : 1'bz;
  assign Terminal_Count_Flag_Out   = Enable_In ?
                                     (Direction_In ? (count_q == '0) : (count_q == term_val)) : 1'bz;
  assign Counter_Count_Out         = Enable_In ? count_q : {WIDTH{1'bz}};

endmodule
